// File: rtl/collision_scheduler.sv
// Collects per-frame ball collision events, snapshots them at frame start,
// and issues one velocity-update request per ball over a valid/ready handshake.
module collision_scheduler #(
  parameter int NUM_BALLS = 4,
  parameter int IDX_W     = $clog2(NUM_BALLS)
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic [NUM_BALLS-1:0] ballDR,
  input  logic                 bordersDR,
  input  logic                 holesDR,
  output logic                 reqValid,
  output logic [IDX_W-1:0]     reqBall,
  output logic [1:0]           reqType,
  input  logic                 reqReady,
  output logic                 busy,
  output logic                 frameDone,
  output logic                 overrunErr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [NUM_BALLS-1:0]      r_pocketF;
  logic [NUM_BALLS-1:0]      r_ballF;
  logic [NUM_BALLS-1:0]      r_borderF;
  logic [NUM_BALLS-1:0]      w_pocketN;
  logic [NUM_BALLS-1:0]      w_ballN;
  logic [NUM_BALLS-1:0]      w_borderN;
  logic [NUM_BALLS-1:0][1:0] r_snap;
  logic [NUM_BALLS-1:0][1:0] w_code;
  logic [IDX_W-1:0]          r_idx;
  logic                      r_overrun;
  logic                      w_multi;
  logic                      w_take;
  logic                      w_last;
  logic                      w_accept;
  logic                      w_adv;
  logic [1:0]                w_cur;

  // Two or more set bits: clearing the lowest set bit leaves something.
  assign w_multi   = |(ballDR & (ballDR - NUM_BALLS'(1)));
  assign w_pocketN = ballDR & {NUM_BALLS{holesDR}};
  assign w_ballN   = ballDR & {NUM_BALLS{w_multi}};
  assign w_borderN = ballDR & {NUM_BALLS{bordersDR}};

  assign w_take   = startOfFrame && (r_state == S_IDLE);
  assign w_cur    = r_snap[r_idx];
  assign w_last   = (r_idx == IDX_W'(NUM_BALLS - 1));
  assign w_accept = (r_state == S_ISSUE) && reqReady;
  assign w_adv    = ((r_state == S_SCAN) && (w_cur == 2'b00))
                  || w_accept;

  always_comb begin
    w_code = '0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      if (r_pocketF[i])      w_code[i] = 2'b11;
      else if (r_ballF[i])   w_code[i] = 2'b10;
      else if (r_borderF[i]) w_code[i] = 2'b01;
      else                   w_code[i] = 2'b00;
    end
  end

  // Same-cycle coincidences land in the freshly cleared flags.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_pocketF <= '0;
      r_ballF   <= '0;
      r_borderF <= '0;
    end else if (w_take) begin
      r_pocketF <= w_pocketN;
      r_ballF   <= w_ballN;
      r_borderF <= w_borderN;
    end else begin
      r_pocketF <= r_pocketF | w_pocketN;
      r_ballF   <= r_ballF | w_ballN;
      r_borderF <= r_borderF | w_borderN;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_snap <= '0;
    end else if (w_take) begin
      r_snap <= w_code;
    end else if (w_accept) begin
      r_snap[r_idx] <= 2'b00;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_idx <= '0;
    end else if (w_take) begin
      r_idx <= '0;
    end else if (w_adv && !w_last) begin
      r_idx <= r_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= startOfFrame && (r_state != S_IDLE);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (startOfFrame) w_next = S_SCAN;
      end
      S_SCAN: begin
        if (w_cur != 2'b00) w_next = S_ISSUE;
        else if (w_last)    w_next = S_DONE;
      end
      S_ISSUE: begin
        if (reqReady) w_next = w_last ? S_DONE : S_SCAN;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    reqValid   = (r_state == S_ISSUE);
    reqBall    = reqValid ? r_idx : '0;
    reqType    = reqValid ? w_cur : 2'b00;
    busy       = (r_state != S_IDLE);
    frameDone  = (r_state == S_DONE);
    overrunErr = r_overrun;
  end

endmodule

// File: tb/tb_collision_scheduler.sv
// Random-stimulus bench for collision_scheduler against a ball-list model
// of frame snapshots and one-request-per-ball servicing.
module tb_collision_scheduler;

  localparam int N  = 4;
  localparam int IW = $clog2(N);

  logic          clk;
  logic          resetN;
  logic          startOfFrame;
  logic [N-1:0]  ballDR;
  logic          bordersDR;
  logic          holesDR;
  logic          reqValid;
  logic [IW-1:0] reqBall;
  logic [1:0]    reqType;
  logic          reqReady;
  logic          busy;
  logic          frameDone;
  logic          overrunErr;

  collision_scheduler #(.NUM_BALLS(N)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .ballDR       (ballDR),
    .bordersDR    (bordersDR),
    .holesDR      (holesDR),
    .reqValid     (reqValid),
    .reqBall      (reqBall),
    .reqType      (reqType),
    .reqReady     (reqReady),
    .busy         (busy),
    .frameDone    (frameDone),
    .overrunErr   (overrunErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int nresets = 0;
  int nreqs = 0;
  int nstall = 0;
  int novr = 0;

  // Model: sticky event sets per ball, a frozen per-ball code list,
  // and the ball currently being attended (cur), plus whether its
  // request is on the wire (presenting) or the frame is wrapping up.
  bit     m_pocket [N];
  bit     m_ball   [N];
  bit     m_border [N];
  int     m_code   [N];
  bit     m_active;
  bit     m_present;
  bit     m_finish;
  int     m_cur;
  bit     m_ovr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pocket[i] = 0;
      m_ball[i]   = 0;
      m_border[i] = 0;
      m_code[i]   = 0;
    end
    m_active  = 0;
    m_present = 0;
    m_finish  = 0;
    m_cur     = 0;
    m_ovr     = 0;
  endtask

  function automatic int code_of(int i);
    if (m_pocket[i]) return 3;
    if (m_ball[i])   return 2;
    if (m_border[i]) return 1;
    return 0;
  endfunction

  task automatic model_step();
    int  cnt;
    bit  was_busy;
    cnt = 0;
    for (int i = 0; i < N; i++) cnt += int'(ballDR[i]);
    was_busy = m_active;
    m_ovr = startOfFrame && was_busy;
    if (startOfFrame && !was_busy) begin
      for (int i = 0; i < N; i++) begin
        m_code[i]   = code_of(i);
        m_pocket[i] = 0;
        m_ball[i]   = 0;
        m_border[i] = 0;
      end
      m_active = 1;
      m_cur    = -1;
    end else if (m_active) begin
      if (m_finish) begin
        m_active = 0;
        m_finish = 0;
      end else if (m_present) begin
        if (reqReady) begin
          m_code[m_cur] = 0;
          m_present = 0;
          if (m_cur == N - 1) m_finish = 1;
        end
      end else begin
        m_cur++;
        if (m_code[m_cur] != 0) m_present = 1;
        else if (m_cur == N - 1) m_finish = 1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (ballDR[i] && holesDR)   m_pocket[i] = 1;
      if (ballDR[i] && cnt >= 2)  m_ball[i]   = 1;
      if (ballDR[i] && bordersDR) m_border[i] = 1;
    end
  endtask

  // The first slot after a snapshot is the examination of ball 0,
  // so cur==-1 means "snapshot just taken, ball 0 next".
  task automatic compare_all();
    logic [31:0] ev, eb, et;
    ev = {31'b0, m_present};
    eb = m_present ? 32'(m_cur) : 32'd0;
    et = m_present ? 32'(m_code[m_cur]) : 32'd0;
    chk("reqValid", {31'b0, reqValid}, ev);
    chk("reqBall", {30'b0, reqBall}, eb);
    chk("reqType", {30'b0, reqType}, et);
    chk("busy", {31'b0, busy}, {31'b0, m_active});
    chk("frameDone", {31'b0, frameDone},
        {31'b0, m_active && m_finish});
    chk("overrunErr", {31'b0, overrunErr}, {31'b0, m_ovr});
    if (reqValid && !reqReady) nstall++;
    if (reqValid && reqReady) nreqs++;
    if (overrunErr) novr++;
  endtask

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    ballDR       = '0;
    bordersDR    = 1'b0;
    holesDR      = 1'b0;
    reqReady     = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare_all();
    resetN = 1'b1;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      compare_all();
      if (cyc > 500 && m_present && nresets < 4
          && $urandom_range(0, 7) == 0) begin
        #1 resetN = 1'b0;
        #1;
        chk("rst_reqValid", {31'b0, reqValid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        model_reset();
        nresets++;
        @(negedge clk);
        resetN = 1'b1;
      end
      startOfFrame = ($urandom_range(0, 11) == 0);
      ballDR       = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      bordersDR    = ($urandom_range(0, 4) == 0);
      holesDR      = ($urandom_range(0, 9) == 0);
      reqReady     = ($urandom_range(0, 1) == 0);
      @(posedge clk);
      model_step();
    end
    chk("reset_exercised", {31'b0, nresets > 0}, 32'd1);
    chk("requests_seen", {31'b0, nreqs > 20}, 32'd1);
    chk("stalls_seen", {31'b0, nstall > 5}, 32'd1);
    chk("overruns_seen", {31'b0, novr > 5}, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
